cpu_instr_sequencer: RTL and testbench
======================================

Name: cpu_instr_sequencer

Overview:
- Program sequencer for the simple CPU.
- Holds a small instruction buffer loaded by a host port.
- On start, it presents each instruction to the CPU `instruction` input for the number of cycles that instruction class needs. Type 2'b00 is treated as HALT.
- Replaces hand-timed instruction driving. Sits between the host/bench and simple_cpu.

Parameters:
- INSTR_WIDTH, 20, instruction word width.
- PC_BITS, 4, buffer address width; DEPTH = 2**PC_BITS words.
- CYC_ALU, 3, cycles each type-01 (ADD/SUB) instruction is held.
- CYC_STORE, 3, cycles each type-11 (STORE_R) instruction is held.
- CYC_LOAD, 4, cycles each type-10 (LOAD_R) instruction is held.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-low reset.
- prog_we  in  1  buffer write enable.
- prog_addr  in  PC_BITS  buffer write address.
- prog_data  in  INSTR_WIDTH  buffer write data.
- start  in  1  begin execution at address 0.
- instruction  out  INSTR_WIDTH  instruction to simple_cpu; registered.
- busy  out  1  high in RUN (and STEP_WAIT).
- done  out  1  one-cycle pulse on program completion.
- pc  out  PC_BITS  address of the instruction currently presented.
- wr_err  out  1  one-cycle pulse: write attempted while busy.

Behaviour:
- Instruction type field = instruction[19:18]:
  - 01 ALU, 10 LOAD_R, 11 STORE_R, 00 HALT/no-op.
  - CPU treats an all-zero word as no-op.
- Reset (rst==0 at edge): state=IDLE, instruction=0, pc=0, busy=0, done=0, wr_err=0, hold counter=0.
- Reset does not clear the buffer. Reset mid-RUN aborts immediately; no done pulse.
- Buffer: DEPTH x INSTR_WIDTH register array, combinational read.
  - Write on edge when prog_we=1 and state==IDLE.
  - prog_we=1 in any other state: write dropped, wr_err=1 next cycle.
- States: IDLE, RUN, DONE (plus STEP_WAIT with the optional feature).
- IDLE:
  - start=1 and mem[0] type!=00 -> RUN; pc<=0, instruction<=mem[0], cnt<=cyc(mem[0])-1.
  - start=1 and mem[0] type==00 -> DONE; instruction stays 0.
  - prog_we and start in the same cycle: write performed first, start uses the new mem[0].
- RUN:
  - Each instruction is held stable on `instruction` for exactly cyc(type) consecutive cycles.
  - cnt decrements each cycle while cnt!=0.
  - When cnt==0, advance:
    - pc==DEPTH-1, or mem[pc+1] type==00 -> DONE, instruction<=0, pc unchanged.
    - otherwise pc<=pc+1, instruction<=mem[pc+1], cnt<=cyc(mem[pc+1])-1.
  - No wrap-around past DEPTH-1.
  - start ignored while busy.
- DONE: done=1 for this single cycle, busy=0, instruction=0; next state IDLE.
- cyc() widths: counter wide enough for max(CYC_*); each CYC_* must be >=1.
- busy is registered with state: high in the same cycle the first instruction appears, low in the DONE cycle.

Optional Feature:
- Macro SEQ_SINGLE_STEP_EN.
- Defined:
  - Adds input port `step` (1 bit).
  - In RUN, when cnt==0 and the program is not ending, go to STEP_WAIT instead of advancing; instruction<=0, pc unchanged, busy=1.
  - STEP_WAIT with step=1: load mem[pc+1] exactly as the RUN advance does, return to RUN.
  - STEP_WAIT with step=0: stay.
  - Ending conditions go to DONE without waiting for step.
- Undefined: no step port, no STEP_WAIT; free-running as above.

Test Plan:
- Reset, load mem[0..2] = 20'b01000111000000000000, 20'b01010011000000000000, 20'b01110010000000000001, mem[3]=0, start -> each word held exactly 3 cycles with pc 0,1,2; done pulses once on cycle 10 after start. CPU regs end [4,7,2,2].
- Program with STORE_R 20'b11011000000011110000 then LOAD_R 20'b10111000000011110000, mem[2]=0 -> store held 3 cycles, load held 4. CPU reg3==7 and data mem[17]==7.
- All DEPTH words non-zero ALU -> runs DEPTH*CYC_ALU cycles, pc stops at DEPTH-1, no wrap, single done pulse.
- prog_we during RUN to addr 1 -> wr_err pulses 1 cycle, mem[1] unchanged; start during RUN ignored.
- rst=0 mid-program (2nd instruction, cnt=1) -> next cycle instruction=0, busy=0, no done. Restart reproduces full program from pc=0.
- With SEQ_SINGLE_STEP_EN: after first instruction's 3 cycles, instruction=0 and busy=1 until step pulses. Step -> next word appears next cycle.

Source files
------------

// File: rtl/cpu_instr_sequencer.sv
// rtl/cpu_instr_sequencer.sv - instruction buffer and timed sequencer feeding simple_cpu
// Optional single-step mode: define SEQ_SINGLE_STEP_EN to add the step input and STEP_WAIT state.
module cpu_instr_sequencer #(
    parameter int INSTR_WIDTH = 20,
    parameter int PC_BITS     = 4,
    parameter int CYC_ALU     = 3,
    parameter int CYC_STORE   = 3,
    parameter int CYC_LOAD    = 4
) (
    input  logic                   clk,
    input  logic                   rst,
`ifdef SEQ_SINGLE_STEP_EN
    input  logic                   step,
`endif
    input  logic                   prog_we,
    input  logic [PC_BITS-1:0]     prog_addr,
    input  logic [INSTR_WIDTH-1:0] prog_data,
    input  logic                   start,
    output logic [INSTR_WIDTH-1:0] instruction,
    output logic                   busy,
    output logic                   done,
    output logic [PC_BITS-1:0]     pc,
    output logic                   wr_err
);

    localparam int DEPTH   = 2 ** PC_BITS;
    localparam int CYC_MAX = (CYC_ALU > CYC_STORE)
                           ? ((CYC_ALU > CYC_LOAD) ? CYC_ALU : CYC_LOAD)
                           : ((CYC_STORE > CYC_LOAD) ? CYC_STORE : CYC_LOAD);
    localparam int CNT_W   = $clog2(CYC_MAX + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
`ifdef SEQ_SINGLE_STEP_EN
        , S_STEP_WAIT
`endif
    } state_t;

    state_t                   state, state_n;
    logic [INSTR_WIDTH-1:0]   mem [DEPTH];
    logic [INSTR_WIDTH-1:0]   instr_n;
    logic [PC_BITS-1:0]       pc_n;
    logic [CNT_W-1:0]         cnt, cnt_n;
    logic                     busy_n, done_n, wr_err_n;

    logic [INSTR_WIDTH-1:0]   mem0_eff;
    logic [PC_BITS-1:0]       pc_inc;
    logic [INSTR_WIDTH-1:0]   next_word;
    logic                     at_last, next_halt;

    // Returns hold count minus one, so the counter reaches zero on the last held cycle.
    function automatic logic [CNT_W-1:0] hold_cnt(input logic [INSTR_WIDTH-1:0] w);
        case (w[INSTR_WIDTH-1 -: 2])
            2'b01:   hold_cnt = CNT_W'(CYC_ALU - 1);
            2'b10:   hold_cnt = CNT_W'(CYC_LOAD - 1);
            2'b11:   hold_cnt = CNT_W'(CYC_STORE - 1);
            default: hold_cnt = '0;
        endcase
    endfunction

    function automatic logic is_halt(input logic [INSTR_WIDTH-1:0] w);
        is_halt = (w[INSTR_WIDTH-1 -: 2] == 2'b00);
    endfunction

    // A write and a start in the same idle cycle: start sees the freshly written word 0.
    assign mem0_eff  = (prog_we && prog_addr == '0) ? prog_data : mem[0];
    assign pc_inc    = pc + PC_BITS'(1);
    assign next_word = mem[pc_inc];
    assign at_last   = (pc == PC_BITS'(DEPTH - 1));
    assign next_halt = is_halt(next_word);

    always_ff @(posedge clk) begin
        if (prog_we && state == S_IDLE) begin
            mem[prog_addr] <= prog_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= S_IDLE;
            instruction <= '0;
            pc          <= '0;
            cnt         <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            wr_err      <= 1'b0;
        end else begin
            state       <= state_n;
            instruction <= instr_n;
            pc          <= pc_n;
            cnt         <= cnt_n;
            busy        <= busy_n;
            done        <= done_n;
            wr_err      <= wr_err_n;
        end
    end

    always_comb begin
        state_n  = state;
        instr_n  = instruction;
        pc_n     = pc;
        cnt_n    = cnt;
        wr_err_n = prog_we && (state != S_IDLE);
        case (state)
            S_IDLE: begin
                if (start) begin
                    if (!is_halt(mem0_eff)) begin
                        state_n = S_RUN;
                        pc_n    = '0;
                        instr_n = mem0_eff;
                        cnt_n   = hold_cnt(mem0_eff);
                    end else begin
                        state_n = S_DONE;
                        instr_n = '0;
                    end
                end
            end
            S_RUN: begin
                if (cnt != '0) begin
                    cnt_n = cnt - CNT_W'(1);
                end else if (at_last || next_halt) begin
                    state_n = S_DONE;
                    instr_n = '0;
                end else begin
`ifdef SEQ_SINGLE_STEP_EN
                    state_n = S_STEP_WAIT;
                    instr_n = '0;
`else
                    pc_n    = pc_inc;
                    instr_n = next_word;
                    cnt_n   = hold_cnt(next_word);
`endif
                end
            end
            S_DONE: begin
                state_n = S_IDLE;
                instr_n = '0;
            end
`ifdef SEQ_SINGLE_STEP_EN
            S_STEP_WAIT: begin
                if (step) begin
                    state_n = S_RUN;
                    pc_n    = pc_inc;
                    instr_n = next_word;
                    cnt_n   = hold_cnt(next_word);
                end
            end
`endif
            default: begin
                state_n = S_IDLE;
                instr_n = '0;
            end
        endcase
`ifdef SEQ_SINGLE_STEP_EN
        busy_n = (state_n == S_RUN) || (state_n == S_STEP_WAIT);
`else
        busy_n = (state_n == S_RUN);
`endif
        done_n = (state_n == S_DONE);
    end

endmodule

// File: tb/tb_cpu_instr_sequencer.sv
// tb/tb_cpu_instr_sequencer.sv - directed self-checking bench for cpu_instr_sequencer
module tb_cpu_instr_sequencer;

    localparam int IW = 20;
    localparam int PB = 4;
    localparam int DEPTH = 16;

    localparam logic [IW-1:0] W0 = 20'b01000111000000000000;
    localparam logic [IW-1:0] W1 = 20'b01010011000000000000;
    localparam logic [IW-1:0] W2 = 20'b01110010000000000001;
    localparam logic [IW-1:0] ST = 20'b11011000000011110000;
    localparam logic [IW-1:0] LD = 20'b10111000000011110000;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          step = 1'b0;
    logic          prog_we = 1'b0;
    logic [PB-1:0] prog_addr = '0;
    logic [IW-1:0] prog_data = '0;
    logic          start = 1'b0;
    logic [IW-1:0] instruction;
    logic          busy, done, wr_err;
    logic [PB-1:0] pc;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    cpu_instr_sequencer dut (
        .clk(clk),
        .rst(rst),
`ifdef SEQ_SINGLE_STEP_EN
        .step(step),
`endif
        .prog_we(prog_we),
        .prog_addr(prog_addr),
        .prog_data(prog_data),
        .start(start),
        .instruction(instruction),
        .busy(busy),
        .done(done),
        .pc(pc),
        .wr_err(wr_err)
    );

    // All stimulus changes and samples happen on the falling edge.
    task automatic write_word(input int a, input logic [IW-1:0] d);
        prog_we   = 1'b1;
        prog_addr = a[PB-1:0];
        prog_data = d;
        @(negedge clk);
        prog_we   = 1'b0;
    endtask

    task automatic load_alu_prog();
        write_word(0, W0);
        write_word(1, W1);
        write_word(2, W2);
        write_word(3, '0);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Entered on the first cycle after start was sampled.
    task automatic check_alu_run(input string tag);
        logic [IW-1:0] words [3];
        words[0] = W0; words[1] = W1; words[2] = W2;
        for (int k = 1; k <= 11; k++) begin
            logic [IW-1:0] ei;
            logic [PB-1:0] ep;
            logic eb, ed;
            if (k <= 9) begin
                ei = words[(k-1)/3]; ep = PB'((k-1)/3); eb = 1'b1; ed = 1'b0;
            end else begin
                ei = '0; ep = PB'(2); eb = 1'b0; ed = (k == 10);
            end
            checks++;
            if (instruction !== ei || pc !== ep || busy !== eb || done !== ed) begin
                failures++;
                $display("FAIL %s cycle %0d: got instr=%h pc=%0d busy=%b done=%b, want instr=%h pc=%0d busy=%b done=%b",
                         tag, k, instruction, pc, busy, done, ei, ep, eb, ed);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (instruction !== '0 || pc !== '0 || busy !== 1'b0 || done !== 1'b0 || wr_err !== 1'b0) begin
            failures++;
            $display("FAIL reset: got instr=%h pc=%0d busy=%b done=%b wr_err=%b, want all zero",
                     instruction, pc, busy, done, wr_err);
        end
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_alu_program();
        load_alu_prog();
        pulse_start();
        check_alu_run("alu_prog");
    endtask

    task automatic test_store_load();
        write_word(0, ST);
        write_word(1, LD);
        write_word(2, '0);
        pulse_start();
        for (int k = 1; k <= 9; k++) begin
            logic [IW-1:0] ei;
            logic [PB-1:0] ep;
            logic eb, ed;
            if (k <= 3)      begin ei = ST; ep = 0; eb = 1; ed = 0; end
            else if (k <= 7) begin ei = LD; ep = 1; eb = 1; ed = 0; end
            else             begin ei = '0; ep = 1; eb = 0; ed = (k == 8); end
            checks++;
            if (instruction !== ei || pc !== ep || busy !== eb || done !== ed) begin
                failures++;
                $display("FAIL store_load cycle %0d: got instr=%h pc=%0d busy=%b done=%b, want instr=%h pc=%0d busy=%b done=%b",
                         k, instruction, pc, busy, done, ei, ep, eb, ed);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_full_depth();
        int dones = 0;
        for (int i = 0; i < DEPTH; i++) write_word(i, 20'h40000 | IW'(i));
        pulse_start();
        for (int k = 1; k <= 50; k++) begin
            logic [IW-1:0] ei;
            logic [PB-1:0] ep;
            logic eb, ed;
            if (k <= 48) begin
                ei = 20'h40000 | IW'((k-1)/3); ep = PB'((k-1)/3); eb = 1; ed = 0;
            end else begin
                ei = '0; ep = PB'(DEPTH-1); eb = 0; ed = (k == 49);
            end
            if (done === 1'b1) dones++;
            checks++;
            if (instruction !== ei || pc !== ep || busy !== eb || done !== ed) begin
                failures++;
                $display("FAIL full_depth cycle %0d: got instr=%h pc=%0d busy=%b done=%b, want instr=%h pc=%0d busy=%b done=%b",
                         k, instruction, pc, busy, done, ei, ep, eb, ed);
            end
            @(negedge clk);
        end
        checks++;
        if (dones != 1) begin
            failures++;
            $display("FAIL full_depth_done_count: got %0d pulses, want 1", dones);
        end
    endtask

    task automatic test_wr_err();
        bit seen = 0;
        int when = 0;
        load_alu_prog();
        pulse_start();
        @(negedge clk);
        prog_we = 1'b1; prog_addr = 1; prog_data = 20'hFFFFF; start = 1'b1;
        @(negedge clk);
        checks++;
        if (wr_err !== 1'b1 || instruction !== W0 || pc !== 0) begin
            failures++;
            $display("FAIL wr_err_pulse: got wr_err=%b instr=%h pc=%0d, want 1 %h 0", wr_err, instruction, pc, W0);
        end
        prog_we = 1'b0; start = 1'b0;
        @(negedge clk);
        checks++;
        if (wr_err !== 1'b0 || instruction !== W1 || pc !== 1) begin
            failures++;
            $display("FAIL wr_err_drop: got wr_err=%b instr=%h pc=%0d, want 0 %h 1", wr_err, instruction, pc, W1);
        end
        for (int c = 4; c <= 20 && !seen; c++) begin
            if (done === 1'b1) begin seen = 1; when = c; end
            else @(negedge clk);
        end
        checks++;
        if (!seen || when != 10) begin
            failures++;
            $display("FAIL wr_err_done: got seen=%0d cycle=%0d, want done at cycle 10", seen, when);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_run();
        pulse_start();
        repeat (4) @(negedge clk);
        checks++;
        if (instruction !== W1 || pc !== 1) begin
            failures++;
            $display("FAIL mid_run_pre: got instr=%h pc=%0d, want %h 1", instruction, pc, W1);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (instruction !== '0 || busy !== 1'b0 || done !== 1'b0 || pc !== '0) begin
            failures++;
            $display("FAIL mid_run_reset: got instr=%h busy=%b done=%b pc=%0d, want 0 0 0 0",
                     instruction, busy, done, pc);
        end
        rst = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                failures++;
                $display("FAIL mid_run_quiet %0d: got done=%b busy=%b, want 0 0", k, done, busy);
            end
        end
        pulse_start();
        check_alu_run("restart");
    endtask

    task automatic test_same_cycle_start();
        bit seen = 0;
        prog_we = 1'b1; prog_addr = 0; prog_data = '0; start = 1'b1;
        @(negedge clk);
        prog_we = 1'b0; start = 1'b0;
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || instruction !== '0) begin
            failures++;
            $display("FAIL halt_first: got done=%b busy=%b instr=%h, want 1 0 0", done, busy, instruction);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0) begin
            failures++;
            $display("FAIL halt_first_single: got done=%b, want 0", done);
        end
        prog_we = 1'b1; prog_addr = 0; prog_data = W0; start = 1'b1;
        @(negedge clk);
        prog_we = 1'b0; start = 1'b0;
        checks++;
        if (instruction !== W0 || busy !== 1'b1 || pc !== 0) begin
            failures++;
            $display("FAIL write_start: got instr=%h busy=%b pc=%0d, want %h 1 0", instruction, busy, pc, W0);
        end
        for (int c = 0; c < 20 && !seen; c++) begin
            if (done === 1'b1) seen = 1;
            else @(negedge clk);
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL write_start_done: got no done pulse within 20 cycles, want one");
        end
        @(negedge clk);
    endtask

`ifdef SEQ_SINGLE_STEP_EN
    task automatic test_single_step();
        bit seen = 0;
        load_alu_prog();
        pulse_start();
        for (int k = 1; k <= 7; k++) begin
            logic [IW-1:0] ei;
            ei = (k <= 3) ? W0 : '0;
            checks++;
            if (instruction !== ei || busy !== 1'b1 || pc !== 0 || done !== 1'b0) begin
                failures++;
                $display("FAIL step_wait cycle %0d: got instr=%h busy=%b pc=%0d done=%b, want %h 1 0 0",
                         k, instruction, busy, pc, done, ei);
            end
            if (k == 7) step = 1'b1;
            @(negedge clk);
        end
        step = 1'b0;
        checks++;
        if (instruction !== W1 || pc !== 1) begin
            failures++;
            $display("FAIL step_advance: got instr=%h pc=%0d, want %h 1", instruction, pc, W1);
        end
        for (int c = 0; c < 30 && !seen; c++) begin
            if (done === 1'b1) seen = 1;
            else begin
                step = (instruction === '0 && busy === 1'b1);
                @(negedge clk);
            end
        end
        step = 1'b0;
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL step_done: got no done pulse within 30 cycles, want one");
        end
    endtask
`endif

    initial begin
        test_reset();
`ifdef SEQ_SINGLE_STEP_EN
        test_single_step();
`else
        test_alu_program();
        test_store_load();
        test_full_depth();
        test_wr_err();
        test_reset_mid_run();
        test_same_cycle_start();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
